// File: rtl/wb_unit_pkg.sv
// Shared encodings for the writeback unit: result select, load size and FSM state.
package wb_unit_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitMem = 2'd1,
        StWrite   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_unit_load_ext.sv
// Load data alignment and sign/zero extension; extension layout assumes 32-bit data.
module wb_unit_load_ext
    import wb_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic [1:0]            off_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] value_o
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  sgn_b;
    logic                  sgn_h;

    assign shifted = mem_rdata_i >> {off_i, 3'b000};
    assign sgn_b   = ~unsigned_i & shifted[7];
    assign sgn_h   = ~unsigned_i & shifted[15];

    always_comb begin
        value_o = mem_rdata_i;
        case (mem_size_e'(size_i))
            MEM_SIZE_B: value_o = {{(DATA_WIDTH - 8){sgn_b}}, shifted[7:0]};
            MEM_SIZE_H: value_o = {{(DATA_WIDTH - 16){sgn_h}}, shifted[15:0]};
            default:    value_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: result select, load wait/extension, regfile write and busy scoreboard.
// Optional macro WBU_BYPASS_EN adds bypass outputs and lets hazard ignore the register being written.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_wen_i,
    input  logic [ADDR_WIDTH-1:0] in_rd_i,
    input  logic [1:0]            in_sel_i,
    input  logic [DATA_WIDTH-1:0] in_alu_res_i,
    input  logic [DATA_WIDTH-1:0] in_pc_i,
    input  logic [DATA_WIDTH-1:0] in_csr_rdata_i,
    input  logic [1:0]            in_mem_size_i,
    input  logic                  in_mem_unsigned_i,
    input  logic [1:0]            in_mem_off_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    input  logic [ADDR_WIDTH-1:0] chk_rs1_i,
    input  logic [ADDR_WIDTH-1:0] chk_rs2_i,
    input  logic [ADDR_WIDTH-1:0] chk_rd_i,
`ifdef WBU_BYPASS_EN
    output logic                  byp_valid_o,
    output logic [ADDR_WIDTH-1:0] byp_rd_o,
    output logic [DATA_WIDTH-1:0] byp_data_o,
`endif
    output logic                  hazard_o,
    output logic                  retire_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    wb_state_e             state_q, state_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [NumRegs-1:0]    busy_q, busy_d;
    logic [NumRegs-1:0]    busy_eff;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_val;
    logic [DATA_WIDTH-1:0] load_val;

    wb_unit_load_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_ext (
        .mem_rdata_i (mem_rdata_i),
        .off_i       (off_q),
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .value_o     (load_val)
    );

    assign in_ready_o = (state_q != StWaitMem);
    assign accept     = in_valid_i && in_ready_o;
    assign retire_o   = (state_q == StWrite);
    assign rf_wen_o   = retire_o && wen_q && (rd_q != '0);
    assign rf_waddr_o = rd_q;
    assign rf_wdata_o = data_q;

    always_comb begin
        sel_val = in_alu_res_i;
        case (wb_sel_e'(in_sel_i))
            WB_SEL_PC4: sel_val = in_pc_i + DATA_WIDTH'(4);
            WB_SEL_CSR: sel_val = in_csr_rdata_i;
            default:    sel_val = in_alu_res_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        rd_d    = rd_q;
        data_d  = data_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        case (state_q)
            StWaitMem: begin
                if (mem_rvalid_i) begin
                    data_d  = load_val;
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Accept is only possible in Idle/Write, so it overrides their next state.
        if (accept) begin
            wen_d   = in_wen_i;
            rd_d    = in_rd_i;
            data_d  = sel_val;
            size_d  = in_mem_size_i;
            uns_d   = in_mem_unsigned_i;
            off_d   = in_mem_off_i;
            state_d = (wb_sel_e'(in_sel_i) == WB_SEL_MEM) ? StWaitMem : StWrite;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (rf_wen_o) begin
            busy_d[rf_waddr_o] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

`ifdef WBU_BYPASS_EN
    assign byp_valid_o = rf_wen_o;
    assign byp_rd_o    = rf_waddr_o;
    assign byp_data_o  = rf_wdata_o;

    always_comb begin
        busy_eff = busy_q;
        if (rf_wen_o) begin
            busy_eff[rf_waddr_o] = 1'b0;
        end
    end
`else
    assign busy_eff = busy_q;
`endif

    assign hazard_o = busy_eff[chk_rs1_i] | busy_eff[chk_rs2_i] | busy_eff[chk_rd_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wen_q   <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            off_q   <= 2'd0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_wb_unit;

`ifdef WBU_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen, in_mem_unsigned, mem_rvalid;
    logic [4:0]  in_rd, rf_waddr, issue_rd, chk_rs1, chk_rs2, chk_rd;
    logic [1:0]  in_sel, in_mem_size, in_mem_off;
    logic [31:0] in_alu_res, in_pc, in_csr_rdata, mem_rdata, rf_wdata;
    logic        rf_wen, issue_valid, hazard, retire;
`ifdef WBU_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the held entry and the busy set.
    bit          m_full = 0, m_wait = 0, m_wen = 0, m_uns = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_val = '0;
    logic [1:0]  m_size = '0, m_off = '0;
    bit          m_busy[32];

    logic        obs_ready, obs_wen, obs_retire, obs_hazard;
    logic [4:0]  obs_waddr;
    logic [31:0] obs_wdata;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_wen_i          (in_wen),
        .in_rd_i           (in_rd),
        .in_sel_i          (in_sel),
        .in_alu_res_i      (in_alu_res),
        .in_pc_i           (in_pc),
        .in_csr_rdata_i    (in_csr_rdata),
        .in_mem_size_i     (in_mem_size),
        .in_mem_unsigned_i (in_mem_unsigned),
        .in_mem_off_i      (in_mem_off),
        .mem_rvalid_i      (mem_rvalid),
        .mem_rdata_i       (mem_rdata),
        .rf_wen_o          (rf_wen),
        .rf_waddr_o        (rf_waddr),
        .rf_wdata_o        (rf_wdata),
        .issue_valid_i     (issue_valid),
        .issue_rd_i        (issue_rd),
        .chk_rs1_i         (chk_rs1),
        .chk_rs2_i         (chk_rs2),
        .chk_rd_i          (chk_rd),
`ifdef WBU_BYPASS_EN
        .byp_valid_o       (byp_valid),
        .byp_rd_o          (byp_rd),
        .byp_data_o        (byp_data),
`endif
        .hazard_o          (hazard),
        .retire_o          (retire)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Load value from the extension rules, using plain arithmetic.
    function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [1:0] sz,
                                          input bit uns, input logic [1:0] off);
        logic [31:0] w, v;
        w = d >> (8 * off);
        if (sz == 2'd0) begin
            v = w % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = w % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic bit m_hz(input logic [4:0] r, input bit ew);
        return (r != 0) && m_busy[r] && !(Byp && ew && (m_rd == r));
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_wen = 0; in_rd = '0; in_sel = '0; in_alu_res = '0; in_pc = '0;
        in_csr_rdata = '0; in_mem_size = '0; in_mem_unsigned = 0; in_mem_off = '0;
        mem_rvalid = 0; mem_rdata = '0; issue_valid = 0; issue_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    task automatic put(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val,
                       input logic [1:0] sz, input bit uns, input logic [1:0] off);
        in_valid = 1; in_wen = 1; in_rd = rd; in_sel = sel;
        in_alu_res = val; in_pc = val; in_csr_rdata = val;
        in_mem_size = sz; in_mem_unsigned = uns; in_mem_off = off;
    endtask

    // Called just after a rising edge: checks this cycle's outputs, then advances the model.
    task automatic step();
        bit er, ew, acc;
        #3;
        er = m_full && !m_wait;
        ew = er && m_wen && (m_rd != 0);
        obs_ready = in_ready; obs_wen = rf_wen; obs_retire = retire; obs_hazard = hazard;
        obs_waddr = rf_waddr; obs_wdata = rf_wdata;
        check_eq("in_ready", 32'(in_ready), 32'(!m_wait));
        check_eq("retire", 32'(retire), 32'(er));
        check_eq("rf_wen", 32'(rf_wen), 32'(ew));
        if (ew) begin
            check_eq("rf_waddr", 32'(rf_waddr), 32'(m_rd));
            check_eq("rf_wdata", rf_wdata, m_val);
        end
        check_eq("hazard", 32'(hazard),
                 32'(m_hz(chk_rs1, ew) | m_hz(chk_rs2, ew) | m_hz(chk_rd, ew)));
`ifdef WBU_BYPASS_EN
        check_eq("byp_valid", 32'(byp_valid), 32'(ew));
        if (ew) begin
            check_eq("byp_rd", 32'(byp_rd), 32'(m_rd));
            check_eq("byp_data", byp_data, m_val);
        end
`endif
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_wait = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            acc = in_valid && !m_wait;
            if (ew) m_busy[m_rd] = 0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
            if (m_wait) begin
                if (mem_rvalid) begin
                    m_val = m_ext(mem_rdata, m_size, m_uns, m_off);
                    m_wait = 0;
                end
            end else if (er && !acc) begin
                m_full = 0;
            end
            if (acc) begin
                m_full = 1; m_wen = in_wen; m_rd = in_rd;
                m_size = in_mem_size; m_uns = in_mem_unsigned; m_off = in_mem_off;
                case (in_sel)
                    2'd1: m_wait = 1;
                    2'd2: m_val = in_pc + 32'd4;
                    2'd3: m_val = in_csr_rdata;
                    default: m_val = in_alu_res;
                endcase
            end
        end
        #1;
    endtask

    task automatic load_test(input bit uns, input logic [31:0] exp);
        idle_inputs();
        put(2'd1, 5'd3, 32'h0, 2'd0, uns, 2'd2);
        step();
        idle_inputs();
        step();
        check_eq("ld_wait_ready", 32'(obs_ready), 32'd0);
        step();
        mem_rvalid = 1; mem_rdata = 32'h0080_0000;
        step();
        idle_inputs();
        step();
        check_eq("ld_wdata", obs_wdata, exp);
        check_eq("ld_wen", 32'(obs_wen), 32'd1);
    endtask

    initial begin
        foreach (m_busy[i]) m_busy[i] = 0;
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        step();
        check_eq("rst_ready", 32'(obs_ready), 32'd1);
        check_eq("rst_hazard", 32'(obs_hazard), 32'd0);
        rst = 0;

        // ALU write to x5 with x5 busy.
        issue_valid = 1; issue_rd = 5'd5;
        step();
        idle_inputs();
        put(2'd0, 5'd5, 32'h1234, 2'd2, 0, 2'd0);
        chk_rs1 = 5'd5;
        step();
        in_valid = 0;
        step();
        check_eq("alu_wdata", obs_wdata, 32'h1234);
        check_eq("alu_waddr", 32'(obs_waddr), 32'd5);
        check_eq("alu_retire", 32'(obs_retire), 32'd1);
        check_eq("alu_hz_wr", 32'(obs_hazard), Byp ? 32'd0 : 32'd1);
        step();
        check_eq("alu_hz_after", 32'(obs_hazard), 32'd0);

        load_test(0, 32'hFFFF_FF80);
        load_test(1, 32'h0000_0080);

        // Back-to-back PC4 then CSR.
        idle_inputs();
        put(2'd2, 5'd1, 32'hFFFF_FFFC, 2'd2, 0, 2'd0);
        step();
        put(2'd3, 5'd2, 32'h0000_00A5, 2'd2, 0, 2'd0);
        step();
        check_eq("b2b_w1", obs_wdata, 32'h0);
        check_eq("b2b_a1", 32'(obs_waddr), 32'd1);
        idle_inputs();
        step();
        check_eq("b2b_w2", obs_wdata, 32'hA5);
        check_eq("b2b_a2", 32'(obs_waddr), 32'd2);

        // rd = 0 retires without writing.
        put(2'd0, 5'd0, 32'hDEAD, 2'd2, 0, 2'd0);
        issue_valid = 1; issue_rd = 5'd0;
        step();
        idle_inputs();
        step();
        check_eq("x0_wen", 32'(obs_wen), 32'd0);
        check_eq("x0_retire", 32'(obs_retire), 32'd1);

        // Re-issue of x7 in its write cycle keeps it busy.
        issue_valid = 1; issue_rd = 5'd7;
        step();
        idle_inputs();
        put(2'd0, 5'd7, 32'h77, 2'd2, 0, 2'd0);
        chk_rs2 = 5'd7;
        step();
        in_valid = 0; issue_valid = 1; issue_rd = 5'd7;
        step();
        issue_valid = 0;
        step();
        check_eq("x7_set_wins", 32'(obs_hazard), 32'd1);

        // Reset while waiting for load data discards the entry.
        idle_inputs();
        put(2'd1, 5'd4, 32'h0, 2'd2, 0, 2'd0);
        step();
        idle_inputs();
        step();
        rst = 1;
        step();
        rst = 0; chk_rs2 = 5'd7;
        step();
        check_eq("rst_wait_ret", 32'(obs_retire), 32'd0);
        check_eq("rst_busy_clr", 32'(obs_hazard), 32'd0);
        mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        step();
        mem_rvalid = 0;
        step();
        check_eq("rst_late_rvalid", 32'(obs_retire), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid        = 1'($urandom_range(0, 1));
            in_wen          = ($urandom % 4) != 0;
            in_rd           = 5'($urandom);
            in_sel          = 2'($urandom);
            in_alu_res      = $urandom;
            in_pc           = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : $urandom;
            in_csr_rdata    = $urandom;
            in_mem_size     = 2'($urandom_range(0, 2));
            in_mem_unsigned = 1'($urandom);
            in_mem_off      = 2'($urandom);
            if (in_mem_size == 2'd1) in_mem_off[0] = 1'b0;
            mem_rvalid      = ($urandom % 3) == 0;
            mem_rdata       = $urandom;
            issue_valid     = 1'($urandom);
            issue_rd        = 5'($urandom);
            chk_rs1         = 5'($urandom);
            chk_rs2         = 5'($urandom);
            chk_rd          = 5'($urandom);
            rst             = ($urandom % 64) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
